// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART receiver and transmitter.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    idle  = 2'd0,
    start = 2'd1,
    data  = 2'd2,
    stop  = 2'd3
  } rx_state_t;

  // Baud ticks per bit; the receiver's tick counter is sized for exactly this.
  localparam int unsigned OVERSAMPLE = 16;
  // Tick index at the middle of the start bit (8th tick after the edge).
  localparam int unsigned MID_TICK   = 7;
  // Tick index one full bit after the previous sample point.
  localparam int unsigned END_TICK   = 15;

  // Clock cycles per oversampling tick, rounded down.
  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, restartable so the tick
// phase can be aligned to an external event (e.g. a start-bit edge).
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // A divider of 0 or 1 would make the tick a constant level, not a pulse.
  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count 0..DIV-1 and pulse on wrap; clear holds the count at zero so the
  // first tick arrives exactly DIV cycles after clear drops.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver with 16x oversampling. Confirms the start
// bit at mid-bit, samples data LSB first one bit apart, and checks the stop bit.
// Presents each byte with a start pulse, a ready level and a framing-error flag.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rx,
  output logic                  rx_new_byte_indicate,
  output logic                  rxByteReady,
  output logic [DATA_WIDTH-1:0] byteFromRx,
  output logic                  frame_error
);

  import uart_pkg::*;

  localparam int unsigned     TICK_DIV = uart_pkg::tick_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned     BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [3:0]      TICK_MID = 4'(MID_TICK);
  localparam logic [3:0]      TICK_END = 4'(END_TICK);

  // The tick counter and sample points are built around 16 ticks per bit.
  if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_oversample
    $error("uart_byte_rx: only OVERSAMPLE=16 is supported");
  end

  // The clock must be at least twice the oversampled baud rate.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("uart_byte_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 2");
  end

  // Synchroniser and frame-tracking state.
  logic                  r_rx_meta;
  logic                  r_rx_s;
  rx_state_t             r_state;
  rx_state_t             w_state_next;
  logic [3:0]            r_tick_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  // Registered outputs.
  logic                  r_new_byte;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_byte;
  logic                  r_ferr;

  // Decoded strobes from the next-state logic.
  logic                  w_tick;
  logic                  w_div_clear;
  logic                  w_mid_tick;
  logic                  w_end_tick;
  logic                  w_start_ok;
  logic                  w_sample;
  logic                  w_commit;

  // Two-flop synchroniser; the line idles high, so reset to 1 avoids a
  // phantom start edge on release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Holding the divider cleared in idle phase-aligns every tick to the start edge.
  assign w_div_clear = (r_state == idle);

  uart_baud_tick #(
    .DIV (TICK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rstN  (rstN),
    .clear (w_div_clear),
    .tick  (w_tick)
  );

  assign w_mid_tick = w_tick && (r_tick_cnt == TICK_MID);
  assign w_end_tick = w_tick && (r_tick_cnt == TICK_END);

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and one-cycle datapath strobes.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_sample     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      idle: begin
        if (!r_rx_s) begin
          w_state_next = start;
        end
      end
      start: begin
        // Line still low at mid start bit: a real frame. High: a glitch.
        if (w_mid_tick) begin
          if (!r_rx_s) begin
            w_state_next = data;
            w_start_ok   = 1'b1;
          end else begin
            w_state_next = idle;
          end
        end
      end
      data: begin
        if (w_end_tick) begin
          w_sample = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = stop;
          end
        end
      end
      stop: begin
        // Sampling mid stop bit leaves half a bit before the next start edge.
        if (w_end_tick) begin
          w_commit     = 1'b1;
          w_state_next = idle;
        end
      end
      default: begin
        w_state_next = idle;
      end
    endcase
  end

  // Tick and bit counters: tick_cnt wraps 15->0 so each sample lands one bit
  // after the previous one; both restart at the confirmed start bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_div_clear || w_start_ok) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      if (w_start_ok) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Right-shift data in at the MSB so the first (LSB) bit ends at bit 0.
  // NOTE: the shift register is reset even though its contents are only
  // consumed after a full frame; it is small and this keeps it X-free.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_shift <= '0;
    end else if (w_sample) begin
      r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
    end
  end

  // Consumer handshake: pulse and ready-fall together on a confirmed start;
  // byte, error flag and ready-rise together on the stop sample. A bad stop
  // bit still commits the byte, with the error flagged.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_new_byte <= 1'b0;
      r_ready    <= 1'b1;
      r_byte     <= '0;
      r_ferr     <= 1'b0;
    end else begin
      r_new_byte <= w_start_ok;
      if (w_start_ok) begin
        r_ready <= 1'b0;
      end
      if (w_commit) begin
        r_byte  <= r_shift;
        r_ferr  <= ~r_rx_s;
        r_ready <= 1'b1;
      end
    end
  end

  assign rx_new_byte_indicate = r_new_byte;
  assign rxByteReady          = r_ready;
  assign byteFromRx           = r_byte;
  assign frame_error          = r_ferr;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: drives 8N1 frames onto rx and checks the byte-side
// handshake against values derived from the frame contents and bit timing.
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned BAUD_RATE = 10_000;
  localparam int unsigned DW        = 8;
  localparam int          TICK_DIV  = CLK_FREQ / (BAUD_RATE * 16);
  localparam int          BIT_CLKS  = TICK_DIV * 16;
  // Edge-to-event latencies: start confirmed 8 ticks in, byte committed
  // after start half-bit + DW data bits + one stop bit.
  localparam int          EXP_PULSE = 2 + TICK_DIV * 8;
  localparam int          EXP_RISE  = 2 + TICK_DIV * (8 + 16 * DW + 16);
  localparam int          TOL       = TICK_DIV;

  logic          clk  = 1'b0;
  logic          rstN = 1'b0;
  logic          rx   = 1'b1;
  logic          rx_new_byte_indicate;
  logic          rxByteReady;
  logic [DW-1:0] byteFromRx;
  logic          frame_error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_WIDTH (DW),
    .OVERSAMPLE (16)
  ) dut (
    .clk                  (clk),
    .rstN                 (rstN),
    .rx                   (rx),
    .rx_new_byte_indicate (rx_new_byte_indicate),
    .rxByteReady          (rxByteReady),
    .byteFromRx           (byteFromRx),
    .frame_error          (frame_error)
  );

  // Cycle counter and event monitor (sampled on the falling edge).
  int            cyc            = 0;
  int            pulses         = 0;
  int            rises          = 0;
  int            hs_bad         = 0;
  int            stab_bad       = 0;
  int            last_pulse_cyc = 0;
  int            last_rise_cyc  = 0;
  logic          prev_ready     = 1'b1;
  logic [DW-1:0] prev_byte      = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_new_byte_indicate === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
      if (rxByteReady !== 1'b0 || prev_ready !== 1'b1) hs_bad++;
    end
    if (rxByteReady === 1'b1 && prev_ready === 1'b0) begin
      rises++;
      last_rise_cyc = cyc;
    end
    if (rxByteReady === 1'b1 && prev_ready === 1'b1 && byteFromRx !== prev_byte) stab_bad++;
    prev_ready = rxByteReady;
    prev_byte  = byteFromRx;
  end

  // Hold rx at v for n clocks; called and returns on a falling edge.
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Send one full frame: start, DW data bits LSB first, stop bit.
  task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit, output int edge_cyc);
    edge_cyc = cyc;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < DW; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(stop_bit, BIT_CLKS);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (rxByteReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", rxByteReady); end
    vectors++; if (rx_new_byte_indicate !== 1'b0) begin miscompares++; $display("FAIL reset_indicate: got %b want 0", rx_new_byte_indicate); end
    vectors++; if (byteFromRx !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", byteFromRx); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
    rstN = 1'b1;
    repeat (50) @(negedge clk);
    vectors++; if (rxByteReady !== 1'b1 || pulses != 0) begin miscompares++; $display("FAIL idle_after_reset: ready %b pulses %0d want 1/0", rxByteReady, pulses); end
  endtask

  task automatic test_single();
    int e, p0, r0, d;
    p0 = pulses; r0 = rises;
    send_frame(8'hA5, 1'b1, e);
    vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    d = last_pulse_cyc - e;
    vectors++; if (d < EXP_PULSE - TOL || d > EXP_PULSE + TOL) begin miscompares++; $display("FAIL single_pulse_latency: got %0d want %0d+-%0d", d, EXP_PULSE, TOL); end
    vectors++; if (rises - r0 != 1) begin miscompares++; $display("FAIL single_rises: got %0d want 1", rises - r0); end
    d = last_rise_cyc - e;
    vectors++; if (d < EXP_RISE - TOL || d > EXP_RISE + TOL) begin miscompares++; $display("FAIL single_ready_latency: got %0d want %0d+-%0d", d, EXP_RISE, TOL); end
    vectors++; if (last_rise_cyc - last_pulse_cyc < BIT_CLKS) begin miscompares++; $display("FAIL single_ready_low: got %0d want >=%0d", last_rise_cyc - last_pulse_cyc, BIT_CLKS); end
    vectors++; if (byteFromRx !== 8'hA5) begin miscompares++; $display("FAIL single_byte: got %h want a5", byteFromRx); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL single_ferr: got %b want 0", frame_error); end
    vectors++; if (rxByteReady !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", rxByteReady); end
  endtask

  task automatic test_back_to_back();
    int e1, e2, p0, r0;
    p0 = pulses; r0 = rises;
    send_frame(8'h34, 1'b1, e1);
    vectors++; if (byteFromRx !== 8'h34) begin miscompares++; $display("FAIL b2b_byte0: got %h want 34", byteFromRx); end
    vectors++; if (rises - r0 != 1) begin miscompares++; $display("FAIL b2b_rise0: got %0d want 1", rises - r0); end
    send_frame(8'h12, 1'b1, e2);
    vectors++; if (byteFromRx !== 8'h12) begin miscompares++; $display("FAIL b2b_byte1: got %h want 12", byteFromRx); end
    vectors++; if (pulses - p0 != 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 2", pulses - p0); end
    vectors++; if (rises - r0 != 2) begin miscompares++; $display("FAIL b2b_rises: got %0d want 2", rises - r0); end
    vectors++; if (last_pulse_cyc - e2 > EXP_PULSE + TOL || last_rise_cyc - last_pulse_cyc < BIT_CLKS) begin
      miscompares++; $display("FAIL b2b_frame1_timing: pulse %0d rise %0d edge %0d", last_pulse_cyc, last_rise_cyc, e2);
    end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL b2b_ferr: got %b want 0", frame_error); end
  endtask

  task automatic test_glitch();
    int p0, r0;
    p0 = pulses; r0 = rises;
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 300);
    vectors++; if (pulses != p0) begin miscompares++; $display("FAIL glitch_pulse: got %0d want 0", pulses - p0); end
    vectors++; if (rxByteReady !== 1'b1 || rises != r0) begin miscompares++; $display("FAIL glitch_ready: got %b rises %0d want 1/0", rxByteReady, rises - r0); end
    vectors++; if (byteFromRx !== 8'h12) begin miscompares++; $display("FAIL glitch_byte: got %h want 12", byteFromRx); end
  endtask

  task automatic test_frame_error();
    int e, p0;
    p0 = pulses;
    send_frame(8'h5A, 1'b0, e);
    drive_bit(1'b1, 200);
    vectors++; if (byteFromRx !== 8'h5A) begin miscompares++; $display("FAIL ferr_byte: got %h want 5a", byteFromRx); end
    vectors++; if (frame_error !== 1'b1) begin miscompares++; $display("FAIL ferr_flag: got %b want 1", frame_error); end
    vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL ferr_pulses: got %0d want 1", pulses - p0); end
    send_frame(8'hFF, 1'b1, e);
    vectors++; if (byteFromRx !== 8'hFF) begin miscompares++; $display("FAIL ferr_next_byte: got %h want ff", byteFromRx); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL ferr_next_flag: got %b want 0", frame_error); end
  endtask

  // Line held low for just over two back-to-back frame lengths, then released
  // before the third frame's start can be confirmed: exactly two error frames.
  task automatic test_break();
    int p0, r0;
    p0 = pulses; r0 = rises;
    drive_bit(1'b0, 3100);
    drive_bit(1'b1, 2000);
    vectors++; if (rises - r0 != 2) begin miscompares++; $display("FAIL break_frames: got %0d want 2", rises - r0); end
    vectors++; if (pulses - p0 != 2) begin miscompares++; $display("FAIL break_pulses: got %0d want 2", pulses - p0); end
    vectors++; if (byteFromRx !== 8'h00) begin miscompares++; $display("FAIL break_byte: got %h want 00", byteFromRx); end
    vectors++; if (frame_error !== 1'b1) begin miscompares++; $display("FAIL break_ferr: got %b want 1", frame_error); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] b;
    int e;
    b = 8'hC3;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(b[4], BIT_CLKS / 2);
    vectors++; if (rxByteReady !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", rxByteReady); end
    rstN = 1'b0;
    #1;
    vectors++; if (rxByteReady !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", rxByteReady); end
    vectors++; if (byteFromRx !== 8'h00 || frame_error !== 1'b0 || rx_new_byte_indicate !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs: byte %h ferr %b ind %b want 00/0/0", byteFromRx, frame_error, rx_new_byte_indicate);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rstN = 1'b1;
    drive_bit(1'b1, 2 * BIT_CLKS);
    vectors++; if (byteFromRx !== 8'h00) begin miscompares++; $display("FAIL midrst_discard: got %h want 00", byteFromRx); end
    send_frame(8'h7E, 1'b1, e);
    vectors++; if (byteFromRx !== 8'h7E || frame_error !== 1'b0 || rxByteReady !== 1'b1) begin
      miscompares++; $display("FAIL midrst_recover: byte %h ferr %b ready %b want 7e/0/1", byteFromRx, frame_error, rxByteReady);
    end
  endtask

  // Random bytes, stop bits and gaps; expected byte/flag come from what was sent.
  task automatic test_random();
    logic prev_bad;
    prev_bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      logic [DW-1:0] b;
      logic          sb;
      int            e, p0, r0, d;
      b  = DW'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      if (prev_bad) drive_bit(1'b1, 40 + int'($urandom_range(0, 60)));
      else          drive_bit(1'b1, int'($urandom_range(0, 100)));
      p0 = pulses; r0 = rises;
      send_frame(b, sb, e);
      vectors++; if (byteFromRx !== b) begin miscompares++; $display("FAIL rand%0d_byte: got %h want %h", n, byteFromRx, b); end
      vectors++; if (frame_error !== ~sb) begin miscompares++; $display("FAIL rand%0d_ferr: got %b want %b", n, frame_error, ~sb); end
      d = last_rise_cyc - e;
      vectors++; if (rises - r0 != 1 || pulses - p0 != 1 || d < EXP_RISE - TOL || d > EXP_RISE + TOL) begin
        miscompares++; $display("FAIL rand%0d_timing: rises %0d pulses %0d latency %0d want 1/1/%0d", n, rises - r0, pulses - p0, d, EXP_RISE);
      end
      prev_bad = ~sb;
    end
    drive_bit(1'b1, 200);
  endtask

  task automatic test_handshake();
    vectors++; if (hs_bad != 0) begin miscompares++; $display("FAIL handshake_same_cycle: got %0d violations want 0", hs_bad); end
    vectors++; if (stab_bad != 0) begin miscompares++; $display("FAIL byte_stable_while_ready: got %0d violations want 0", stab_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_break();
    test_reset_mid_frame();
    test_random();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
